// File: rtl/prog_gate_pkg.sv
// ============================================================================
// Module   : prog_gate_pkg
// Brief    : Truth-table encodings and a bitwise reference function for the
//            programmable gate pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_gate_pkg;

  typedef logic [3:0] lut_t;

  // Bit k of a table is the output for {a,b} == k.
  localparam lut_t LUT_AND  = 4'b1000;
  localparam lut_t LUT_OR   = 4'b1110;
  localparam lut_t LUT_XOR  = 4'b0110;
  localparam lut_t LUT_NAND = 4'b0111;
  localparam lut_t LUT_NOR  = 4'b0001;
  localparam lut_t LUT_XNOR = 4'b1001;
  localparam lut_t LUT_A    = 4'b1100;
  localparam lut_t LUT_B    = 4'b1010;

  localparam int REF_MAX_W = 64;

  function automatic logic [REF_MAX_W-1:0] gate_ref(
    input lut_t                 lut,
    input logic [REF_MAX_W-1:0] a,
    input logic [REF_MAX_W-1:0] b
  );
    logic [REF_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < REF_MAX_W; i++) begin
      r[i] = lut[{a[i], b[i]}];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lut_mux4.sv
// ============================================================================
// Module   : lut_mux4
// Brief    : One-bit 4:1 mux selecting a truth-table entry by {a,b}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_mux4
  import prog_gate_pkg::*;
(
  input  logic [3:0] lut,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  assign y = lut[{a, b}];

endmodule

`default_nettype wire

// File: rtl/prog_gate_pipe.sv
// ============================================================================
// Module   : prog_gate_pipe
// Brief    : WIDTH-bit programmable two-input gate with a registered
//            valid/ready output stage backed by a one-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_gate_pipe
  import prog_gate_pkg::*;
#(
  parameter int         WIDTH   = 8,
  parameter int         CNT_W   = 16,
  parameter logic [3:0] LUT_RST = LUT_AND
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_lut,
  output logic [3:0]       lut_q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] txn_cnt
);

  logic [3:0]       r_lut;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_y_next;
  logic             w_accept;
  logic             w_deliver;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      lut_mux4 u_mux (
        .lut (r_lut),
        .a   (a[gi]),
        .b   (b[gi]),
        .y   (w_y_next[gi])
      );
    end
  endgenerate

  // in_ready comes straight off the skid flop, so out_ready never reaches it.
  assign w_accept  = in_valid && !r_skid_valid;
  assign w_deliver = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lut <= LUT_RST;
    end else if (cfg_we) begin
      r_lut <= cfg_lut;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_deliver) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_data <= w_y_next;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_out_valid) begin
        r_out_data  <= w_y_next;
        r_out_valid <= 1'b1;
      end else begin
        r_skid_data  <= w_y_next;
        r_skid_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_deliver) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign lut_q     = r_lut;
  assign in_ready  = !r_skid_valid;
  assign out_valid = r_out_valid;
  assign y         = r_out_data;
  assign txn_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prog_gate_pipe.sv
// ============================================================================
// Module   : tb_prog_gate_pipe
// Brief    : Scoreboard bench for prog_gate_pipe (WIDTH=8, CNT_W=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_gate_pipe;
  import prog_gate_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             cfg_we;
  logic [3:0]       cfg_lut;
  logic [3:0]       lut_q;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] txn_cnt;

  prog_gate_pipe #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .LUT_RST (4'b1000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_lut   (cfg_lut),
    .lut_q     (lut_q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .txn_cnt   (txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [WIDTH-1:0] sb[$];
  logic [3:0]       m_lut;
  logic [CNT_W-1:0] m_cnt;
  logic [WIDTH-1:0] last_y;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Independent sum-of-minterms model of the programmable gate.
  function automatic logic [WIDTH-1:0] ref_y(input logic [3:0] lut,
                                             input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] bv);
    return ({WIDTH{lut[3]}} &  av &  bv) |
           ({WIDTH{lut[2]}} &  av & ~bv) |
           ({WIDTH{lut[1]}} & ~av &  bv) |
           ({WIDTH{lut[0]}} & ~av & ~bv);
  endfunction

  // Monitor: sampled mid-cycle, a deliver happens at the following edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("txn_cnt", 32'(txn_cnt), 32'(m_cnt));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(out_valid), 32'd0);
        end else begin
          chk("y_order", 32'(y), 32'(sb.pop_front()));
        end
        last_y = y;
        m_cnt  = m_cnt + 1'b1;
      end
    end
  end

  task automatic drive(input logic do_cfg, input logic [3:0] lut, input logic do_op,
                       input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       output int cyc);
    logic done;
    done     = 1'b0;
    cyc      = 0;
    cfg_we   = do_cfg;
    cfg_lut  = lut;
    in_valid = do_op;
    a        = av;
    b        = bv;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (!do_op || in_ready) begin
        if (do_op) sb.push_back(ref_y(m_lut, av, bv));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cfg_we) begin
        m_lut  = cfg_lut;
        cfg_we = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int c;
    drive(1'b0, 4'h0, 1'b1, av, bv, c);
  endtask

  task automatic set_lut(input logic [3:0] lut);
    int c;
    drive(1'b1, lut, 1'b0, '0, '0, c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("drain_timeout", sb.size(), 0);
  endtask

  logic [3:0] sweep_lut [8];
  logic [7:0] sweep_exp [8];

  initial begin
    int tot;
    int c;
    sweep_lut = '{LUT_AND, LUT_OR, LUT_XOR, LUT_NAND, LUT_NOR, LUT_XNOR, LUT_A, LUT_B};
    sweep_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'hCC};
    m_lut = 4'b1000; m_cnt = '0; last_y = '0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_lut = '0; in_valid = 1'b0;
    a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_lut", 32'(lut_q), 32'h8);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_cnt", 32'(txn_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Default table, one-cycle latency
    send(8'hF0, 8'hCC);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_y", 32'(y), 32'hC0);
    drain();
    chk("first_cnt", 32'(txn_cnt), 32'd1);

    for (int i = 0; i < 8; i++) begin
      set_lut(sweep_lut[i]);
      chk("lut_q", 32'(lut_q), 32'(sweep_lut[i]));
      send(8'hF0, 8'hCC);
      drain();
      chk("sweep_y", 32'(last_y), 32'(sweep_exp[i]));
    end

    // Backpressure into the skid entry
    set_lut(LUT_AND);
    out_ready = 1'b0;
    send(8'h01, 8'hFF);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    send(8'h02, 8'hFF);
    chk("bp_ready0", 32'(in_ready), 32'd0);
    fork
      send(8'h03, 8'hFF);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_y", 32'(y), 32'h01);
          chk("bp_stall", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_last_y", 32'(last_y), 32'h03);
    chk("bp_ready_back", 32'(in_ready), 32'd1);

    // Table write on the accept edge: old table for that operand
    drive(1'b1, LUT_OR, 1'b1, 8'hAA, 8'h55, c);
    drain();
    chk("coll_old", 32'(last_y), 32'h00);
    send(8'hAA, 8'h55);
    drain();
    chk("coll_new", 32'(last_y), 32'hFF);

    // Asynchronous reset with both entries full
    set_lut(LUT_XOR);
    out_ready = 1'b0;
    send(8'h11, 8'h22);
    send(8'h33, 8'h44);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_y", 32'(y), 32'd0);
    chk("arst_cnt", 32'(txn_cnt), 32'd0);
    chk("arst_lut", 32'(lut_q), 32'h8);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    m_cnt = '0;
    m_lut = 4'b1000;
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(8'hF0, 8'hCC);
    drain();
    chk("post_rst_y", 32'(last_y), 32'hC0);

    // Back-to-back stream through the counter wrap
    tot = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 4'h0, 1'b1, 8'(i * 37), 8'(8'hA5 ^ i), c);
      tot += c;
    end
    chk("throughput", tot, 9);
    drain();
    chk("wrap_final", 32'(txn_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d tests run expected completion", n_tests);
    $fatal(1);
  end

endmodule

`default_nettype wire
